// File: rtl/alu_mul_seq.sv
// rtl/alu_mul_seq.sv - shift-add 8-bit multiplier sequencer driving the shared combinational ALU
module alu_mul_seq #(
  parameter bit EARLY_EXIT = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] op_a,
  input  logic [7:0] op_b,
  output logic       busy,
  output logic       done,
  output logic [7:0] result,
  output logic [3:0] alu_sel,
  output logic [7:0] alu_a,
  output logic [7:0] alu_b,
  input  logic [7:0] alu_c,
  input  logic       alu_cmp
);

  localparam logic [3:0] SEL_ADD  = 4'd5;
  localparam logic [3:0] SEL_SHL  = 4'd7;
  localparam logic [3:0] SEL_SHR  = 4'd8;
  localparam logic [3:0] SEL_ZERO = 4'd10;

  typedef enum logic [2:0] {
    S_IDLE,
    S_TEST,
    S_ADD,
    S_SHL,
    S_SHR,
    S_DONE
  } state_t;

  state_t     state_q;
  state_t     state_d;
  logic [7:0] acc;
  logic [7:0] mcand;
  logic [7:0] mplier;
  logic [3:0] cnt;
  logic       exit_now;

  // Early exit trusts the ALU zero flag; otherwise a fixed 8-iteration count.
  assign exit_now = (EARLY_EXIT != 1'b0) ? alu_cmp : (cnt == 4'd8);

  always_comb begin
    state_d = state_q;
    alu_sel = 4'd0;
    alu_a   = 8'd0;
    alu_b   = 8'd0;
    case (state_q)
      S_IDLE: begin
        if (start) state_d = S_TEST;
      end
      S_TEST: begin
        alu_sel = SEL_ZERO;
        alu_a   = mplier;
        if (exit_now)       state_d = S_DONE;
        else if (mplier[0]) state_d = S_ADD;
        else                state_d = S_SHL;
      end
      S_ADD: begin
        alu_sel = SEL_ADD;
        alu_a   = acc;
        alu_b   = mcand;
        state_d = S_SHL;
      end
      S_SHL: begin
        alu_sel = SEL_SHL;
        alu_a   = mcand;
        alu_b   = 8'd1;
        state_d = S_SHR;
      end
      S_SHR: begin
        alu_sel = SEL_SHR;
        alu_a   = mplier;
        alu_b   = 8'd1;
        state_d = S_TEST;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      result  <= 8'd0;
      acc     <= 8'd0;
      mcand   <= 8'd0;
      mplier  <= 8'd0;
      cnt     <= 4'd0;
    end else begin
      state_q <= state_d;
      // Flags follow the next state so they line up with the state they describe.
      busy    <= (state_d != S_IDLE);
      done    <= (state_d == S_DONE);
      case (state_q)
        S_IDLE: begin
          if (start) begin
            acc    <= 8'd0;
            mcand  <= op_a;
            mplier <= op_b;
            cnt    <= 4'd0;
          end
        end
        S_TEST: begin
          if (exit_now) result <= acc;
        end
        S_ADD: acc   <= alu_c;
        S_SHL: mcand <= alu_c;
        S_SHR: begin
          mplier <= alu_c;
          cnt    <= cnt + 4'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/alu_mul_seq.md
Name: alu_mul_seq

Overview:
- Multi-cycle sequencer that computes the 8-bit product (low byte, mod 256) of two operands by driving the shared 8-bit ALU through shift-add steps.
- The ALU stays combinational; this block owns its sel/A/B inputs while busy and registers every ALU result into its own working registers.
- Sits beside the control unit. It is started with a one-cycle start pulse and reports completion with a one-cycle done pulse.

Parameters:
- EARLY_EXIT, 1, 1 = finish as soon as the remaining multiplier is zero; 0 = always run exactly 8 iterations.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- start  in  1  request; sampled only in IDLE
- op_a  in  8  multiplicand, captured when start is accepted
- op_b  in  8  multiplier, captured when start is accepted
- busy  out  1  registered; high from the cycle after start is accepted through the DONE cycle
- done  out  1  registered; one-cycle pulse, result valid
- result  out  8  registered product low byte; held until the next accepted start
- alu_sel  out  4  ALU op select (combinational from state)
- alu_a  out  8  ALU A operand
- alu_b  out  8  ALU B operand
- alu_c  in  8  ALU result
- alu_cmp  in  1  ALU compare flag

Behaviour:
- Reset is asynchronous and active-high. It forces state IDLE and clears busy, done, result, acc, mcand, mplier and cnt. Reset mid-operation abandons the operation; no done pulse is produced.
- Internal registers: acc[8], mcand[8], mplier[8], cnt[4].
- IDLE: ALU outputs are 0/0/0.
  - When start=1, load acc=0, mcand=op_a, mplier=op_b, cnt=0, and go to TEST.
  - When start=0, stay in IDLE.
- TEST: alu_sel=10 (zero test), alu_a=mplier, alu_b=0.
  - With EARLY_EXIT=1, exit when alu_cmp=1. With EARLY_EXIT=0, exit when cnt==8.
  - On exit: result<=acc and go to DONE.
  - Otherwise go to ADD if mplier[0]=1, else to SHL.
- ADD: alu_sel=5, alu_a=acc, alu_b=mcand. acc<=alu_c, then go to SHL. The carry is discarded and wraps mod 256.
- SHL: alu_sel=7, alu_a=mcand, alu_b=1. mcand<=alu_c, then go to SHR.
- SHR: alu_sel=8 (logical shift), alu_a=mplier, alu_b=1. mplier<=alu_c and cnt<=cnt+1, then go to TEST.
- DONE: done=1 for exactly this cycle, busy=1, ALU outputs 0/0/0. Always go to IDLE next.
- start is ignored in every state other than IDLE, including DONE. The earliest back-to-back start is accepted in the cycle after DONE.
- Iteration cost: 3 cycles when the multiplier bit is 0, 4 cycles when it is 1.
- Latency: the accepting edge, then the sum of iteration cycles, then 1 TEST cycle, then the DONE cycle.
- Signed operands: the low-byte product is identical for two's-complement and unsigned operands. No special handling is needed.
- result changes only on the TEST→DONE transition and on reset.
- busy and done are never high while the state is IDLE.

Test Plan:
1. Reset, then op_a=3, op_b=5, start pulse -> TEST/ADD/SHL/SHR sequence with 11 iteration cycles plus a final TEST; done pulses 13 cycles after the accepting edge with result=15; busy falls the cycle after done.
2. op_a=20, op_b=20 -> result=0x90 (400 mod 256); op_a=0xFD (-3), op_b=5 -> result=0xF1 (-15).
3. op_b=0 with EARLY_EXIT=1 -> TEST immediately exits; done in the 2nd cycle after acceptance, result=0. Same input with EARLY_EXIT=0 -> 8 iterations of 3 cycles, result=0, done in the 26th cycle.
4. start held high for the whole operation, with op_a/op_b changed mid-run -> exactly one operation, using the captured operands. A second operation is accepted in the cycle after DONE; no start is accepted in the DONE cycle.
5. Assert rst during an ADD state of 7*9 -> busy/done/result go to 0 immediately without waiting for a clock edge; no done pulse. A following start with 7*9 gives result=63.
6. Each state drives the ALU outputs listed above: TEST=10, ADD=5, SHL=7, SHR=8; IDLE/DONE drive 0/0/0. Check with an ALU model in the loop; compare against a reference product for 200 random operand pairs.
